bfg_mux_sweep_checker: RTL and testbench
========================================

Name: bfg_mux_sweep_checker

Overview:
- Self-checking stimulus/compare engine for generated-vs-standard-cell mux pairs, parametrised in select width.
- Drives a shared data/select vector onto both muxes through user I/O, waits a settle time, then samples both outputs.
- Compares each output against an internal golden mux, counts errors per implementation and captures the first failing vector.
- Sits between the user_project_wrapper pads and the mux pair under test; replaces manual pad toggling.

Parameters:
- SEL_BITS, 2, select width; N = 2**SEL_BITS data inputs; legal range 1..3; vector width V = N + SEL_BITS (at most 11).
- SETTLE_CYCLES, 2, wait cycles between drive and sample; minimum 2, which covers the 2-flop input synchroniser.
- CNT_WIDTH, 16, width of the error counters; counters saturate.
- NUM_RAND, 256, number of vectors applied in random mode.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE.
- abort  in  1  forces DONE at the next edge from DRIVE, SETTLE or CHECK.
- mode  in  1  0 = exhaustive sweep, 1 = LFSR random; sampled on start.
- seed  in  16  LFSR seed; sampled on start; a value of 0 is replaced by 16'h0001.
- gf_in  in  1  standard-cell mux output (asynchronous, from a pad).
- bfg_in  in  1  generated mux output (asynchronous, from a pad).
- mux_data  out  N  registered data inputs to both muxes.
- mux_sel  out  SEL_BITS  registered select to both muxes.
- busy  out  1  high in DRIVE, SETTLE and CHECK.
- done  out  1  high in DONE.
- aborted  out  1  set when a run ends via abort; cleared on start.
- gf_err_count  out  CNT_WIDTH  saturating count of gf mismatches.
- bfg_err_count  out  CNT_WIDTH  saturating count of bfg mismatches.
- first_fail_valid  out  1  a failure has been captured in this run.
- first_fail_vec  out  V  first failing vector, encoded {sel, data}.
- first_fail_which  out  2  bit 1 = gf failed, bit 0 = bfg failed, both for the captured vector.

Behaviour:
- Reset:
  - All outputs and counters go to 0; state = IDLE; LFSR = 16'h0001.
  - Reset has priority over start and abort, including mid-run.
- Vector encoding: v[N-1:0] is data, v[V-1:N] is sel. Expected output = data[sel].
- Vector source:
  - Exhaustive mode: v counts 0 .. 2**V-1 in order.
  - Random mode: 16-bit Galois LFSR, right shift, tap mask 16'hB400. v = lfsr[V-1:0]. The LFSR steps once per vector. Exactly NUM_RAND vectors are applied; the first vector uses the seed itself.
- Input synchroniser: gf_in and bfg_in each pass through a 2-flop synchroniser that runs continuously.
- FSM:
  - IDLE/DONE --start--> DRIVE. On this transition: clear both counters, first_fail_*, aborted; load the vector source.
  - DRIVE (1 cycle): register v onto mux_data and mux_sel → SETTLE.
  - SETTLE: exactly SETTLE_CYCLES cycles → CHECK.
  - CHECK (1 cycle):
    - gf_err = sync_gf != expected; bfg_err = sync_bfg != expected.
    - Increment each counter on its error, saturating at all-ones.
    - If first_fail_valid is 0 and either error is set: capture vec and which, then set first_fail_valid.
    - If this was the last vector → DONE; otherwise advance the source → DRIVE.
  - DONE: hold all results; done = 1 until the next start or reset.
- Per-vector period = SETTLE_CYCLES + 2 cycles. A run of M vectors keeps busy high for M*(SETTLE_CYCLES+2) cycles; done rises on the cycle after the last CHECK.
- mux_data and mux_sel hold their last value in DONE and IDLE.
- start while busy is ignored.
- abort while busy → DONE next edge with aborted = 1; counts and captured failure up to that point are retained.
- abort and start in the same cycle while in IDLE or DONE: start wins and abort is ignored.
- Counter saturation: at all-ones, further errors leave the count unchanged.

Test Plan:
- SEL_BITS=2, SETTLE=2, mode 0, ideal models (gf = bfg = data[sel]) → busy for 256 cycles, done = 1, both counts 0, first_fail_valid = 0.
- Same setup, bfg_in stuck at 0 → bfg_err_count = 32, gf_err_count = 0, first_fail_vec = 6'b00_0001, first_fail_which = 2'b01.
- CNT_WIDTH=4, gf_in and bfg_in both stuck at 1 → both counts saturate at 15; first_fail_vec = 0, first_fail_which = 2'b11.
- Mode 1, seed = 0, NUM_RAND=256, ideal models → the first driven vector equals 16'h0001[5:0]; exactly 256 CHECK cycles; counts 0.
- Abort asserted during the 10th vector's SETTLE → DONE on the next edge, aborted = 1, counts reflect 9 vectors. A following start clears aborted and runs the full sweep.
- wb_rst_i pulsed mid-run → on the next cycle state = IDLE and all outputs = 0. A start in the same cycle as reset is ignored.

Source files
------------

// File: rtl/bfg_mux_sweep_checker.sv
// Stimulus/compare engine for a generated vs standard-cell mux pair.
// Drives {sel,data} vectors, waits for the pads to settle, then checks both outputs against data[sel].
module bfg_mux_sweep_checker #(
    parameter int SEL_BITS      = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_WIDTH     = 16,
    parameter int NUM_RAND      = 256,
    localparam int N            = 2 ** SEL_BITS,
    localparam int V            = N + SEL_BITS
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 mode,
    input  logic [15:0]          seed,
    input  logic                 gf_in,
    input  logic                 bfg_in,
    output logic [N-1:0]         mux_data,
    output logic [SEL_BITS-1:0]  mux_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [CNT_WIDTH-1:0] gf_err_count,
    output logic [CNT_WIDTH-1:0] bfg_err_count,
    output logic                 first_fail_valid,
    output logic [V-1:0]         first_fail_vec,
    output logic [1:0]           first_fail_which
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int IW = 17;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

    state_t          state_reg, state_next;
    logic            load, drive_en, do_check, abort_hit;
    logic            mode_reg;
    logic [15:0]     lfsr_reg, lfsr_next;
    logic [IW-1:0]   idx_reg;
    logic [SW-1:0]   settle_cnt_reg;
    logic [V-1:0]    cur_vec;
    logic            is_last;
    logic [1:0]      async_in, sync_bits;
    logic            expected, gf_err, bfg_err;

    // Pad inputs are asynchronous: two flops each, always running.
    assign async_in = {gf_in, bfg_in};
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic meta_reg, sync_reg;
        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                meta_reg <= 1'b0;
                sync_reg <= 1'b0;
            end else begin
                meta_reg <= async_in[gi];
                sync_reg <= meta_reg;
            end
        end
        assign sync_bits[gi] = sync_reg;
    end

    assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    assign cur_vec   = mode_reg ? lfsr_reg[V-1:0] : idx_reg[V-1:0];
    assign is_last   = mode_reg ? (idx_reg == IW'(NUM_RAND - 1)) : (idx_reg == IW'(2 ** V - 1));
    assign expected  = mux_data[mux_sel];
    assign gf_err    = sync_bits[1] != expected;
    assign bfg_err   = sync_bits[0] != expected;

    assign busy = (state_reg == DRIVE) || (state_reg == SETTLE) || (state_reg == CHECK);
    assign done = (state_reg == DONE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        drive_en   = 1'b0;
        do_check   = 1'b0;
        abort_hit  = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = DRIVE;
                    load       = 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_next = DONE;
                    abort_hit  = 1'b1;
                end else begin
                    state_next = SETTLE;
                    drive_en   = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_next = DONE;
                    abort_hit  = 1'b1;
                end else if (settle_cnt_reg == SW'(SETTLE_CYCLES - 1)) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_next = DONE;
                    abort_hit  = 1'b1;
                end else begin
                    do_check   = 1'b1;
                    state_next = is_last ? DONE : DRIVE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            mode_reg         <= 1'b0;
            lfsr_reg         <= 16'h0001;
            idx_reg          <= '0;
            settle_cnt_reg   <= '0;
            mux_data         <= '0;
            mux_sel          <= '0;
            aborted          <= 1'b0;
            gf_err_count     <= '0;
            bfg_err_count    <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_which <= 2'b00;
        end else begin
            if (load) begin
                mode_reg         <= mode;
                lfsr_reg         <= (seed == 16'h0000) ? 16'h0001 : seed;
                idx_reg          <= '0;
                aborted          <= 1'b0;
                gf_err_count     <= '0;
                bfg_err_count    <= '0;
                first_fail_valid <= 1'b0;
                first_fail_vec   <= '0;
                first_fail_which <= 2'b00;
            end
            if (abort_hit) aborted <= 1'b1;
            if (drive_en) begin
                mux_data       <= cur_vec[N-1:0];
                mux_sel        <= cur_vec[V-1:N];
                settle_cnt_reg <= '0;
            end
            if (state_reg == SETTLE) settle_cnt_reg <= settle_cnt_reg + SW'(1);
            if (do_check) begin
                if (gf_err && (gf_err_count != '1))   gf_err_count  <= gf_err_count + CNT_WIDTH'(1);
                if (bfg_err && (bfg_err_count != '1)) bfg_err_count <= bfg_err_count + CNT_WIDTH'(1);
                if (!first_fail_valid && (gf_err || bfg_err)) begin
                    first_fail_valid <= 1'b1;
                    first_fail_vec   <= {mux_sel, mux_data};
                    first_fail_which <= {gf_err, bfg_err};
                end
                // Source only advances when another vector follows, so it holds the last one in DONE.
                if (!is_last) begin
                    idx_reg  <= idx_reg + IW'(1);
                    lfsr_reg <= lfsr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_bfg_mux_sweep_checker.sv
// Directed bench: mux pair models with selectable faults, a vector table of full runs,
// plus hand-written abort, LFSR-start and reset sequences.
module tb_bfg_mux_sweep_checker;

    logic        clk = 1'b0;
    logic        rst, start, abort, mode;
    logic [15:0] seed;
    logic [1:0]  gf_fault, bfg_fault;

    logic [3:0]  m_data, s_data;
    logic [1:0]  m_sel, s_sel;
    logic        busy, done, aborted, ffv;
    logic        s_busy, s_done, s_aborted, s_ffv;
    logic [15:0] gf_cnt, bfg_cnt;
    logic [3:0]  s_gf_cnt, s_bfg_cnt;
    logic [5:0]  ffvec, s_ffvec;
    logic [1:0]  ffwhich, s_ffwhich;
    logic        gf_in, bfg_in, s_gf_in, s_bfg_in;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // fault: 0 ideal, 1 stuck at 0, 2 stuck at 1, 3 inverted
    function automatic logic mux_model(logic [3:0] d, logic [1:0] s, logic [1:0] f);
        case (f)
            2'd0:    return d[s];
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return ~d[s];
        endcase
    endfunction

    assign gf_in    = mux_model(m_data, m_sel, gf_fault);
    assign bfg_in   = mux_model(m_data, m_sel, bfg_fault);
    assign s_gf_in  = mux_model(s_data, s_sel, gf_fault);
    assign s_bfg_in = mux_model(s_data, s_sel, bfg_fault);

    bfg_mux_sweep_checker #(.SEL_BITS(2), .SETTLE_CYCLES(2), .CNT_WIDTH(16), .NUM_RAND(256)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort), .mode(mode), .seed(seed),
        .gf_in(gf_in), .bfg_in(bfg_in), .mux_data(m_data), .mux_sel(m_sel), .busy(busy),
        .done(done), .aborted(aborted), .gf_err_count(gf_cnt), .bfg_err_count(bfg_cnt),
        .first_fail_valid(ffv), .first_fail_vec(ffvec), .first_fail_which(ffwhich)
    );

    bfg_mux_sweep_checker #(.SEL_BITS(2), .SETTLE_CYCLES(2), .CNT_WIDTH(4), .NUM_RAND(256)) dut_small (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort), .mode(mode), .seed(seed),
        .gf_in(s_gf_in), .bfg_in(s_bfg_in), .mux_data(s_data), .mux_sel(s_sel), .busy(s_busy),
        .done(s_done), .aborted(s_aborted), .gf_err_count(s_gf_cnt), .bfg_err_count(s_bfg_cnt),
        .first_fail_valid(s_ffv), .first_fail_vec(s_ffvec), .first_fail_which(s_ffwhich)
    );

    typedef struct {
        logic        mode;
        logic [15:0] seed;
        logic [1:0]  gff, bff;
        int          busy_cycles;
        int          gfc, bfc, sgfc, sbfc;
        logic        ffv;
        logic [5:0]  vec;
        logic [1:0]  which;
    } run_t;

    run_t tbl[6];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Runs until done; pulses start once mid-run, which must be ignored.
    task automatic wait_done(output int cycles);
        int guard;
        cycles = 0;
        guard  = 0;
        while (!done && guard < 5000) begin
            if (busy) cycles++;
            start = (cycles == 20);
            guard++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("run_timeout", {31'd0, guard < 5000}, 32'd1);
    endtask

    task automatic run_entry(int i);
        int cyc;
        gf_fault  = tbl[i].gff;
        bfg_fault = tbl[i].bff;
        mode      = tbl[i].mode;
        seed      = tbl[i].seed;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("busy_cycles", cyc, tbl[i].busy_cycles);
        chk("done", {31'd0, done}, 32'd1);
        chk("gf_err_count", gf_cnt, tbl[i].gfc);
        chk("bfg_err_count", bfg_cnt, tbl[i].bfc);
        chk("small_gf_err_count", s_gf_cnt, tbl[i].sgfc);
        chk("small_bfg_err_count", s_bfg_cnt, tbl[i].sbfc);
        chk("first_fail_valid", {31'd0, ffv}, {31'd0, tbl[i].ffv});
        if (tbl[i].ffv) begin
            chk("first_fail_vec", ffvec, tbl[i].vec);
            chk("first_fail_which", ffwhich, tbl[i].which);
        end
        if (!tbl[i].mode) chk("mux_hold_last", {m_sel, m_data}, 6'h3F);
        $display("run %0d mode=%0d seed=%h gf_fault=%0d bfg_fault=%0d busy=%0d gf=%0d bfg=%0d",
                 i, tbl[i].mode, tbl[i].seed, tbl[i].gff, tbl[i].bff, cyc, gf_cnt, bfg_cnt);
    endtask

    // First three LFSR vectors, observed during each vector's first SETTLE cycle, then abort.
    task automatic rand_seq(logic [15:0] s, logic [5:0] e0, logic [5:0] e1, logic [5:0] e2);
        gf_fault  = 2'd0;
        bfg_fault = 2'd0;
        mode      = 1'b1;
        seed      = s;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("lfsr_vec0", {m_sel, m_data}, e0);
        repeat (4) @(negedge clk);
        chk("lfsr_vec1", {m_sel, m_data}, e1);
        repeat (4) @(negedge clk);
        chk("lfsr_vec2", {m_sel, m_data}, e2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("lfsr_abort_done", {30'd0, done, aborted}, 32'd3);
        $display("lfsr seq seed=%h vecs=%h,%h,%h", s, e0, e1, e2);
    endtask

    initial begin
        int cyc;
        tbl[0] = '{1'b0, 16'h0000, 2'd0, 2'd0, 256,  0,   0,  0,  0, 1'b0, 6'h00, 2'b00};
        tbl[1] = '{1'b0, 16'h0000, 2'd0, 2'd1, 256,  0,   32, 0,  15, 1'b1, 6'h01, 2'b01};
        tbl[2] = '{1'b0, 16'h0000, 2'd2, 2'd2, 256,  32,  32, 15, 15, 1'b1, 6'h00, 2'b11};
        tbl[3] = '{1'b0, 16'h0000, 2'd3, 2'd0, 256,  64,  0,  15, 0,  1'b1, 6'h00, 2'b10};
        tbl[4] = '{1'b1, 16'h0000, 2'd0, 2'd0, 1024, 0,   0,  0,  0,  1'b0, 6'h00, 2'b00};
        tbl[5] = '{1'b1, 16'h00A5, 2'd3, 2'd0, 1024, 256, 0,  15, 0,  1'b1, 6'h25, 2'b10};

        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; seed = 16'h0000;
        gf_fault = 2'd0; bfg_fault = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset_flags", {28'd0, busy, done, aborted, ffv}, 32'd0);
        chk("reset_counts", {gf_cnt, bfg_cnt}, 32'd0);
        chk("reset_vectors", {ffwhich, ffvec, m_sel, m_data}, 32'd0);
        $display("reset state busy=%0d done=%0d", busy, done);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_entry(i);

        rand_seq(16'h0000, 6'h01, 6'h00, 6'h00);
        rand_seq(16'h00A5, 6'h25, 6'h12, 6'h29);

        // Abort in vector 9's SETTLE: vectors 0..8 checked, bfg fails on v=1,3,5,7.
        gf_fault = 2'd0; bfg_fault = 2'd1; mode = 1'b0; seed = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (37) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_state", {29'd0, busy, done, aborted}, 32'd3);
        chk("abort_bfg_count", bfg_cnt, 32'd4);
        chk("abort_gf_count", gf_cnt, 32'd0);
        chk("abort_first_fail", {ffv, ffvec, ffwhich}, {23'd0, 1'b1, 6'h01, 2'b01});
        $display("abort run bfg=%0d gf=%0d aborted=%0d", bfg_cnt, gf_cnt, aborted);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("restart_state", {29'd0, busy, done, aborted}, 32'd4);
        chk("restart_cleared", {bfg_cnt, 15'd0, ffv}, 32'd0);
        wait_done(cyc);
        chk("restart_busy_cycles", cyc, 32'd256);
        chk("restart_bfg_count", bfg_cnt, 32'd32);
        chk("restart_aborted", {31'd0, aborted}, 32'd0);
        $display("restart run busy=%0d bfg=%0d", cyc, bfg_cnt);

        // Reset mid-run with a simultaneous start.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("midrst_flags", {28'd0, busy, done, aborted, ffv}, 32'd0);
        chk("midrst_counts", {gf_cnt, bfg_cnt}, 32'd0);
        chk("midrst_vectors", {ffwhich, ffvec, m_sel, m_data}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("midrst_start_ignored", {30'd0, busy, done}, 32'd0);
        $display("mid-run reset busy=%0d done=%0d", busy, done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
